// File: rtl/pkg_matriz.sv
// Shared constants, state encoding and row/column helpers for the
// 7x5 dot-matrix scan driver.
package pkg_matriz;

   localparam int NUM_LINHAS  = 7;
   localparam int NUM_COLUNAS = 5;
   localparam int NUM_BITS    = NUM_LINHAS * NUM_COLUNAS;

   localparam logic [NUM_LINHAS-1:0] LINHA_OFF = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } estado_t;

   // Active-low one-hot row drive; out-of-range codes give all rows off.
   function automatic logic [NUM_LINHAS-1:0] linha_onehot(input logic [2:0] r);
      return ~(NUM_LINHAS'(1) << r);
   endfunction

   function automatic logic [NUM_COLUNAS-1:0] colunas_da_linha(
      input logic [NUM_BITS-1:0] p,
      input logic [2:0]          r
   );
      return p[int'(r)*NUM_COLUNAS +: NUM_COLUNAS];
   endfunction

endpackage

// File: rtl/modulo_varredura_matriz_if.sv
// Pattern-in / matrix-pins-out bundle between the encoder layer and the
// scan driver.
interface modulo_varredura_matriz_if
   import pkg_matriz::*;
   ;

   logic                   en;
   logic [NUM_BITS-1:0]    padrao;
   logic [NUM_LINHAS-1:0]  linha;
   logic [NUM_COLUNAS-1:0] coluna;
   logic                   frame_start;

   modport master (
      output en, padrao,
      input  linha, coluna, frame_start
   );

   modport slave (
      input  en, padrao,
      output linha, coluna, frame_start
   );

endinterface

// File: rtl/modulo_divisor_varredura.sv
// Row-slot prescaler: counts 0..DIV-1 while run is high, flags the last
// blanking cycle and the last cycle of the slot.
module modulo_divisor_varredura #(
   parameter int DIV   = 50000,
   parameter int BLANK = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tc,
   output logic blank_end
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] count;

   assign tc        = (count == W'(DIV - 1));
   assign blank_end = (count == W'(BLANK - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (run) begin
         count <= tc ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Multiplexed 7x5 LED matrix scan driver: frame-coherent snapshot of the
// pattern, one row lit at a time with a dark gap at the start of each slot.
module modulo_varredura_matriz
   import pkg_matriz::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   modulo_varredura_matriz_if.slave    bus
);

   localparam logic [2:0] ULTIMA_LINHA = 3'(NUM_LINHAS - 1);

   estado_t             state, state_next;
   logic [2:0]          row, row_next;
   logic [NUM_BITS-1:0] snapshot, snapshot_next;
   logic                frame_start_next;
   logic                presc_clr, presc_run;
   logic                tc, blank_end;

   modulo_divisor_varredura #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_divisor (
      .clk       (clk),
      .rst       (rst),
      .clr       (presc_clr),
      .run       (presc_run),
      .tc        (tc),
      .blank_end (blank_end)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next       = state;
      row_next         = row;
      snapshot_next    = snapshot;
      frame_start_next = 1'b0;
      presc_clr        = 1'b0;
      presc_run        = 1'b0;

      unique case (state)
         ST_IDLE: begin
            presc_clr = 1'b1;
            if (bus.en) begin
               snapshot_next    = bus.padrao;
               row_next         = '0;
               frame_start_next = 1'b1;
               state_next       = ST_BLANK;
            end
         end

         ST_BLANK: begin
            if (!bus.en) begin
               presc_clr  = 1'b1;
               row_next   = '0;
               state_next = ST_IDLE;
            end else begin
               presc_run = 1'b1;
               if (blank_end) state_next = ST_SHOW;
            end
         end

         ST_SHOW: begin
            if (!bus.en) begin
               presc_clr  = 1'b1;
               row_next   = '0;
               state_next = ST_IDLE;
            end else begin
               presc_run = 1'b1;
               if (tc) begin
                  state_next = ST_BLANK;
                  if (row == ULTIMA_LINHA) begin
                     // End of frame: take the next coherent snapshot.
                     row_next         = '0;
                     snapshot_next    = bus.padrao;
                     frame_start_next = 1'b1;
                  end else begin
                     row_next = row + 3'd1;
                  end
               end
            end
         end

         default: begin
            presc_clr  = 1'b1;
            row_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so the pins change on the
   // same edge the state does.
   // NOTE: the 35-bit snapshot is an ordinary register bank, so it is reset
   // along with the rest of the state rather than left uninitialised.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         row             <= '0;
         snapshot        <= '0;
         bus.linha       <= LINHA_OFF;
         bus.coluna      <= '0;
         bus.frame_start <= 1'b0;
      end else begin
         state           <= state_next;
         row             <= row_next;
         snapshot        <= snapshot_next;
         bus.frame_start <= frame_start_next;
         if (state_next == ST_SHOW) begin
            bus.linha  <= linha_onehot(row_next);
            bus.coluna <= colunas_da_linha(snapshot_next, row_next);
         end else begin
            bus.linha  <= LINHA_OFF;
            bus.coluna <= '0;
         end
      end
   end

endmodule

// File: doc/modulo_varredura_matriz.md
# modulo_varredura_matriz

Multiplexed scan driver for the 7-row × 5-column LED dot-matrix display. It consumes the 5-bit row patterns produced by the per-row preset encoders and lights one row at a time, with a blanking gap between rows to suppress ghosting. It takes a frame-coherent snapshot of all 35 pattern bits, so a pattern that changes mid-frame never tears. It sits between the preset/encoder layer and the matrix pins.

## Interface
- `DIV`, default 50000: clock cycles per row slot, including blanking. Must satisfy `DIV` > `BLANK` + 1.
- `BLANK`, default 2: cycles at the start of each row slot with all rows off. Must be ≥ 1.
- `clk`, in, 1: single system clock; everything is registered on its rising edge.
- `rst`, in, 1: synchronous, active-high reset. It has priority over every other input.
- `en`, in, 1: scan enable. When low, the display is dark.
- `padrao`, in, 35: pattern input. Bits [5r+4:5r] are the columns of row r+1 (r = 0..6). Bit 0 of each group is column 1.
- `linha`, out, 7: row drive, one-hot, active-low. Bit r drives row r+1.
- `coluna`, out, 5: column drive, active-high.
- `frame_start`, out, 1: one-cycle pulse, asserted when a new snapshot is taken.

## Operation
- The block has three states: IDLE, BLANK and SHOW. It also holds a row counter (0..6), a prescaler (0..DIV-1) and a 35-bit snapshot register.
- Reset values:
  - state = IDLE
  - row = 0, prescaler = 0, snapshot = 0
  - `linha` = 7'h7F
  - `coluna` = 0
  - `frame_start` = 0
- IDLE:
  - Outputs are dark (`linha` = 7'h7F, `coluna` = 0).
  - If `en` = 1: capture `padrao` into the snapshot, set row = 0 and prescaler = 0, pulse `frame_start`, and go to BLANK.
- BLANK:
  - Outputs are dark.
  - The prescaler increments each cycle.
  - When prescaler = BLANK-1, go to SHOW on the next edge.
- SHOW:
  - `linha[row]` = 0 and all other bits of `linha` = 1.
  - `coluna` = snapshot[5·row+4 : 5·row].
  - The prescaler increments each cycle.
  - When prescaler = DIV-1: reset the prescaler to 0 and go to BLANK.
    - If row < 6, increment row.
    - If row = 6, wrap row to 0, recapture `padrao` into the snapshot, and pulse `frame_start`.
- `en` = 0 in BLANK or SHOW: on the next edge go to IDLE. Outputs go dark, row and prescaler return to 0, and the snapshot is retained. `en` low overrides the row-advance and wrap logic in that same cycle.
- `padrao` is sampled only at frame start. Changes to it mid-frame are ignored until the next frame.
- The pattern is passed through unchanged: no arithmetic and no inversion on `coluna`.

## Timing
- All outputs are registered and change only on `clk` edges.
- If `en` is first seen high at edge k:
  - `frame_start` = 1 during cycle k+1.
  - Cycles k+1 .. k+BLANK are dark.
  - Row 1 is lit during cycles k+BLANK+1 .. k+DIV.
- Row slot length is exactly `DIV` cycles: `BLANK` cycles dark, then `DIV`-`BLANK` cycles lit.
- Frame period is 7·`DIV` cycles. The spacing between `frame_start` pulses is exactly 7·`DIV` cycles while `en` stays high.
- `frame_start` on wrap is asserted in the first BLANK cycle of row 1.
- `en` falling: outputs are dark starting the cycle after the edge where `en` = 0 is sampled.
- `rst` mid-operation: on the next edge, all reset values apply regardless of `en`. Once `rst` is released with `en` = 1, the next edge behaves as the IDLE→BLANK transition.
- Prescaler width is $clog2(`DIV`). Row counter width is 3 bits; codes 7 and above are unreachable.
- Never more than one `linha` bit is low. `coluna` is 0 whenever `linha` = 7'h7F.

## Structure
- Shared package, `pkg_matriz`, holds:
  - `NUM_LINHAS` = 7, `NUM_COLUNAS` = 5
  - `LINHA_OFF` = 7'h7F
  - state encodings `ST_IDLE` = 2'd0, `ST_BLANK` = 2'd1, `ST_SHOW` = 2'd2
- One sub-module, `modulo_divisor_varredura`: a parameterized prescaler with sync clear, a terminal-count output (prescaler = DIV-1), and a blank-end output (prescaler = BLANK-1).
- The FSM, row counter, snapshot register and output registers are in the top module.

## Test plan
The bench uses `DIV` = 8 and `BLANK` = 2 throughout.
- **Reset:** hold `rst` = 1 with `en` = 1 for 3 cycles → `linha` = 7'h7F, `coluna` = 0, `frame_start` = 0 on every cycle.
- **First row:** row 1 pattern = 5'b11011, `en` rises and is sampled at edge k → `frame_start` = 1 only in cycle k+1; cycles k+1..k+2 dark; cycles k+3..k+8 show `linha` = 7'b1111110, `coluna` = 5'b11011.
- **Wrap and snapshot:** while row 3 is lit, change `padrao` → the current frame still shows the old values. Exactly 56 cycles after the first `frame_start`, `frame_start` pulses again, and the new row 1 value appears at cycle +3 of that frame.
- **Row mapping:** `padrao` has only row 7 = 5'b10001 → `coluna` = 5'b10001 only while `linha` = 7'b0111111, and `coluna` = 0 in all other cycles.
- **Enable drop:** deassert `en` mid-SHOW of row 4 → outputs dark on the next cycle. Re-asserting `en` restarts at row 1 with a `frame_start` pulse.
- **Mid-operation reset:** `rst` pulse during SHOW of row 5 with `en` held high → outputs dark the next cycle. After release, the full first-row timing from scenario 2 repeats.
